// File: rtl/rt_pkg.sv
// Shared ray-tracing types for the triangle scan controller: coordinates, vectors,
// triangles, rays and the scan FSM state encoding.
package rt_pkg;

    typedef logic signed [31:0] coord_t;
    typedef coord_t [2:0]       vec3_t;
    typedef vec3_t [2:0]        tri_t;

    // Index 1 is the ray origin, index 0 is the direction.
    typedef vec3_t [1:0]        ray_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_TEST,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/tri_scan_ctrl_if.sv
// Signal bundle for tri_scan_ctrl: scan command, triangle fetch bus, intersect
// datapath operands/results and the closest-hit result.
interface tri_scan_ctrl_if #(
    parameter int TRI_IDX_W = 16
);
    import rt_pkg::*;

    logic                  i_start;
    ray_t                  i_ray;
    logic [TRI_IDX_W-1:0]  i_num_tris;

    logic                  o_tri_req;
    logic [TRI_IDX_W-1:0]  o_tri_addr;
    logic                  i_tri_valid;
    tri_t                  i_tri;

    tri_t                  o_isect_tri;
    ray_t                  o_isect_ray;
    logic                  i_isect_hit;
    logic                  i_isect_ovf;
    logic signed [31:0]    i_isect_t;

    logic                  o_busy;
    logic                  o_done;
    logic                  o_hit;
    logic [TRI_IDX_W-1:0]  o_hit_idx;
    logic signed [31:0]    o_hit_t;
    logic                  o_ovf;

    modport slave (
        input  i_start, i_ray, i_num_tris,
        output o_tri_req, o_tri_addr,
        input  i_tri_valid, i_tri,
        output o_isect_tri, o_isect_ray,
        input  i_isect_hit, i_isect_ovf, i_isect_t,
        output o_busy, o_done, o_hit, o_hit_idx, o_hit_t, o_ovf
    );

    modport master (
        output i_start, i_ray, i_num_tris,
        input  o_tri_req, o_tri_addr,
        output i_tri_valid, i_tri,
        input  o_isect_tri, o_isect_ray,
        output i_isect_hit, i_isect_ovf, i_isect_t,
        input  o_busy, o_done, o_hit, o_hit_idx, o_hit_t, o_ovf
    );

endinterface

// File: rtl/tri_scan_ctrl_hit_tracker.sv
// hit_tracker: keeps the closest accepted hit of a scan. A candidate wins only
// with a strictly smaller signed t, so ties keep the earlier (lower) index.
module hit_tracker #(
    parameter int IDX_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                cand_valid,
    input  logic signed [31:0]  cand_t,
    input  logic [IDX_W-1:0]    cand_idx,
    output logic                best_hit,
    output logic [IDX_W-1:0]    best_idx,
    output logic signed [31:0]  best_t,
    output logic                take
);

    assign take = cand_valid && (!best_hit || (cand_t < best_t));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_hit <= 1'b0;
            best_idx <= '0;
            best_t   <= '0;
        end else if (clear) begin
            best_hit <= 1'b0;
            best_idx <= '0;
            best_t   <= '0;
        end else if (take) begin
            best_hit <= 1'b1;
            best_idx <= cand_idx;
            best_t   <= cand_t;
        end
    end

endmodule

// File: rtl/tri_scan_ctrl.sv
// tri_scan_ctrl: fetches N triangles one at a time, feeds them to an external
// intersect datapath and reports the closest hit. Optional TRI_SCAN_ANY_HIT_EN stops at the first hit.
module tri_scan_ctrl
    import rt_pkg::*;
#(
    parameter int                 TRI_IDX_W = 16,
    parameter logic signed [31:0] MIN_T     = 0
) (
    input  logic           i_clk,
    input  logic           i_reset,
    tri_scan_ctrl_if.slave bus
);

    // MIN_T belongs to the intersect datapath; it is only carried here.
    localparam logic signed [31:0]   unused_min_t = MIN_T;
    localparam logic [TRI_IDX_W-1:0] IDX_ONE      = TRI_IDX_W'(1);

    scan_state_t state;
    scan_state_t next_state;

    logic [TRI_IDX_W-1:0] idx;
    logic [TRI_IDX_W-1:0] count;
    ray_t                 ray_q;
    tri_t                 tri_q;
    logic                 ovf_q;

    logic                 accept;
    logic                 last_tri;
    logic                 cand_valid;
    logic                 take;
    logic                 best_hit;
    logic [TRI_IDX_W-1:0] best_idx;
    logic signed [31:0]   best_t;

    assign accept     = (state == ST_IDLE) && bus.i_start;
    assign last_tri   = (idx == (count - IDX_ONE));
    assign cand_valid = (state == ST_TEST) && bus.i_isect_hit && !bus.i_isect_ovf;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    next_state = (bus.i_num_tris == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.i_tri_valid) begin
                    next_state = ST_TEST;
                end
            end
            ST_TEST: begin
`ifdef TRI_SCAN_ANY_HIT_EN
                if (take || last_tri) begin
`else
                if (last_tri) begin
`endif
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_FETCH;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy    = (state != ST_IDLE);
        bus.o_done    = (state == ST_DONE);
        bus.o_tri_req = (state == ST_FETCH);
    end

    // Scan bookkeeping; idx only advances when another fetch follows, so it never wraps.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idx   <= '0;
            count <= '0;
            ray_q <= '0;
            tri_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        ray_q <= bus.i_ray;
                        count <= bus.i_num_tris;
                        idx   <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (bus.i_tri_valid) begin
                        tri_q <= bus.i_tri;
                    end
                end
                ST_TEST: begin
                    if (bus.i_isect_ovf) begin
                        ovf_q <= 1'b1;
                    end
                    if (next_state == ST_FETCH) begin
                        idx <= idx + IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    hit_tracker #(
        .IDX_W (TRI_IDX_W)
    ) u_hit_tracker (
        .clk        (i_clk),
        .rst        (i_reset),
        .clear      (accept),
        .cand_valid (cand_valid),
        .cand_t     (bus.i_isect_t),
        .cand_idx   (idx),
        .best_hit   (best_hit),
        .best_idx   (best_idx),
        .best_t     (best_t),
        .take       (take)
    );

    assign bus.o_tri_addr  = idx;
    assign bus.o_isect_tri = tri_q;
    assign bus.o_isect_ray = ray_q;
    assign bus.o_hit       = best_hit;
    assign bus.o_hit_idx   = best_idx;
    assign bus.o_hit_t     = best_t;
    assign bus.o_ovf       = ovf_q;

endmodule

// File: doc/tri_scan_ctrl.md
TRI_SCAN_CTRL -- requirements
Module: tri_scan_ctrl

Interface
REQ-001 The block SHALL have parameter TRI_IDX_W, default 16, width of triangle index and count.
REQ-002 The block SHALL have parameter signed MIN_T, default 0, passed to the intersect datapath; not used internally.
REQ-003 The block SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port i_reset  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_start  input  1  begin scan; sampled in IDLE only.
REQ-006 The block SHALL have port i_ray  input  signed 32 x [1:0][2:0]  [1] origin, [0] direction.
REQ-007 The block SHALL have port i_num_tris  input  TRI_IDX_W  triangle count, sampled with i_start.
REQ-008 The block SHALL have port o_tri_req  output  1  triangle fetch request.
REQ-009 The block SHALL have port o_tri_addr  output  TRI_IDX_W  index of requested triangle.
REQ-010 The block SHALL have port i_tri_valid  input  1  fetch data valid.
REQ-011 The block SHALL have port i_tri  input  signed 32 x [2:0][2:0]  fetched corners.
REQ-012 The block SHALL have port o_isect_tri / o_isect_ray  output  same shapes  registered operands to the combinational intersect datapath.
REQ-013 The block SHALL have port i_isect_hit, i_isect_ovf  input  1 each  datapath hit and overflow.
REQ-014 The block SHALL have port i_isect_t  input  signed 32  datapath t.
REQ-015 The block SHALL have port o_busy  output  1  high outside IDLE.
REQ-016 The block SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-017 The block SHALL have ports o_hit (1), o_hit_idx (TRI_IDX_W) and o_hit_t (signed 32), all outputs, giving the closest-hit result.
REQ-018 The block SHALL have port o_ovf  output  1  sticky: any tested triangle overflowed.

Function
REQ-019 The block SHALL implement states IDLE, FETCH, TEST, DONE.
REQ-020 IDLE + i_start: latch i_ray into o_isect_ray, latch i_num_tris, clear o_hit, o_hit_idx, o_hit_t and o_ovf, set idx=0; go to FETCH if count>0, else DONE.
REQ-021 FETCH: o_tri_req=1, o_tri_addr=idx held stable until i_tri_valid; on i_tri_valid latch i_tri into o_isect_tri and go to TEST.
REQ-022 One outstanding fetch only; i_tri_valid outside FETCH SHALL be ignored.
REQ-023 TEST (one cycle): if i_isect_ovf, set o_ovf and do not update; else if i_isect_hit and (!o_hit or i_isect_t < o_hit_t, signed), set o_hit=1, o_hit_idx=idx, o_hit_t=i_isect_t.
REQ-024 Equal t SHALL keep the earlier (lower) index.
REQ-025 TEST exit: if idx==count-1 go to DONE, else idx+1 and go to FETCH; no index wrap.
REQ-026 DONE: o_done=1 for exactly one cycle, then IDLE; result outputs hold until the next accepted i_start.
REQ-027 i_start while busy SHALL be ignored; i_start in the DONE cycle SHALL be ignored.
REQ-028 With fetch latency L>=1 (valid L cycles after FETCH entry), cost SHALL be L+2 cycles per triangle; o_done asserts in cycle 1+N(L+2) after the i_start cycle.

Reset
REQ-029 i_reset SHALL force IDLE with all outputs 0, idx=0 and o_isect_* =0, from any state including mid-fetch; a late i_tri_valid is ignored.

Configuration
REQ-030 With TRI_SCAN_ANY_HIT_EN defined, the first accepted hit in TEST SHALL go directly to DONE (shadow-ray any-hit); without it, all N triangles SHALL be scanned.

Structure
REQ-031 Package rt_pkg SHALL hold vec3_t, tri_t, ray_t typedefs and the state enum.
REQ-032 The compare/update logic SHALL be sub-module hit_tracker (clear, update-enable, t, idx in; best hit, idx, t out).

Verification
REQ-033 N=0, start -> o_done at cycle 1, o_hit=0, o_tri_req never asserted.
REQ-034 N=3, L=1, hits t=50,20,20 -> o_hit_idx=1, o_hit_t=20, o_done at cycle 10.
REQ-035 N=4, triangle 2 raises ovf and hit t=5, others miss -> o_hit=0, o_ovf=1.
REQ-036 i_reset at the second FETCH with valid arriving afterwards -> IDLE, all outputs 0, no TEST entered.
REQ-037 TRI_SCAN_ANY_HIT_EN, N=5, first hit at idx 1 -> o_done after 2 triangles, o_hit_idx=1, o_tri_addr never 2.
REQ-038 Variable latency L=1..4 with i_start pulsed while busy -> addr stable, start ignored, result unchanged.
